// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op codes, FSM states and command layout for alu_op_sequencer
// Shared by the sequencer top and its testbench; no ports.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

  localparam logic [7:0] DIV0_RESULT = 8'hFF;

  // FIFO entry layout {op, b, a}; op lands in the top bits.
  typedef struct packed {
    op_e        op;
    logic [3:0] b;
    logic [3:0] a;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic logic is_div0(input op_e op, input logic [3:0] b);
    return (op == OP_DIV) && (b == 4'd0);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - command, ALU and response bundle for alu_op_sequencer
// Signals:
//   cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op  command port into the sequencer
//   alu_a/alu_b/alu_s -> alu_y              combinational ALU driven by the sequencer
//   rsp_valid/rsp_ready/rsp_y/rsp_err       response port out of the sequencer
// master = sequencer side, slave = command source / ALU / response sink.
interface alu_op_sequencer_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_op;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_s;
  logic [7:0] alu_y;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_y;
  logic       rsp_err;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    output cmd_ready,
    output alu_a, alu_b, alu_s,
    input  alu_y,
    output rsp_valid, rsp_y, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    input  cmd_ready,
    input  alu_a, alu_b, alu_s,
    output alu_y,
    input  rsp_valid, rsp_y, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - command FIFO for alu_op_sequencer
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (empties the FIFO)
//   push, wdata  write strobe and entry; ignored while full
//   pop          read strobe; ignored while empty
//   rdata        head entry (valid while !empty)
//   full, empty  occupancy flags
module alu_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit: equal low bits with differing top bit means full.
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - queues ALU commands, drives the ALU, returns registered results
// Ports:
//   clk       single clock, rising edge
//   rst_n     synchronous active-low reset
//   bus       alu_op_sequencer_if.master: command in, ALU out/in, response out
//   busy      FSM not idle or FIFO not empty
//   op_count  responses completed, wraps
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_op_sequencer_if.master   bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  state_e state_q;
  state_e state_d;
  cmd_t   push_cmd;
  cmd_t   head_cmd;
  logic   fifo_full;
  logic   fifo_empty;
  logic   push;
  logic   pop;
  logic   capture;
  logic   retire;

  assign push_cmd = '{op: op_e'(bus.cmd_op), b: bus.cmd_b, a: bus.cmd_a};

  // Ready comes only from FIFO space: a command never bypasses the FIFO.
  assign bus.cmd_ready = rst_n && !fifo_full;
  assign push          = bus.cmd_valid && bus.cmd_ready;

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_cmd),
    .pop   (pop),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_valid && bus.rsp_ready) begin
          retire  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.alu_s     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_y     <= '0;
      bus.rsp_err   <= 1'b0;
      op_count      <= '0;
    end else begin
      state_q <= state_d;
      // ALU operands move only on a pop, so they stay stable through RESP.
      if (pop) begin
        bus.alu_a <= head_cmd.a;
        bus.alu_b <= head_cmd.b;
        bus.alu_s <= head_cmd.op;
      end
      if (capture) begin
        bus.rsp_valid <= 1'b1;
        if (is_div0(op_e'(bus.alu_s), bus.alu_b)) begin
          bus.rsp_y   <= DIV0_RESULT;
          bus.rsp_err <= 1'b1;
        end else begin
          bus.rsp_y   <= bus.alu_y;
          bus.rsp_err <= 1'b0;
        end
      end
      if (retire) begin
        bus.rsp_valid <= 1'b0;
        op_count      <= op_count + CNT_W'(1);
      end
    end
  end

  assign busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int vectors    = 0;
  int miscompares = 0;

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(
    .FIFO_DEPTH (4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // Combinational ALU attached to the sequencer; yields 0 on divide by zero.
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    case (s)
      2'd0:    return 8'(a) + 8'(b);
      2'd1:    return 8'(a) - 8'(b);
      2'd2:    return 8'(a) * 8'(b);
      default: return (b == 4'd0) ? 8'h00 : 8'(a / b);
    endcase
  endfunction

  assign bus.alu_y = alu_fn(bus.alu_a, bus.alu_b, bus.alu_s);

  // Reference response {err, y} computed from the operation's meaning.
  function automatic logic [8:0] ref_rsp(input int a, input int b, input int op);
    int r;
    if (op == 3 && b == 0) return {1'b1, 8'hFF};
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a * b;
      default: r = a / b;
    endcase
    return {1'b0, 8'(r)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: commands enter exp_q when accepted, responses must leave in order.
  logic [8:0] exp_q [$];
  logic [8:0] got_q [$];
  int         exp_count = 0;
  logic       hold_chk  = 1'b0;
  logic [8:0] held      = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_count = 0;
      hold_chk  = 1'b0;
    end else begin
      check("op_count", op_count, exp_count % (1 << CNT_W));
      if (hold_chk) begin
        check("hold_valid", bus.rsp_valid, 1);
        check("hold_rsp", {bus.rsp_err, bus.rsp_y}, held);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        check("rsp_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("rsp_order", {bus.rsp_err, bus.rsp_y}, exp_q.pop_front());
        got_q.push_back({bus.rsp_err, bus.rsp_y});
        exp_count++;
      end
      hold_chk = bus.rsp_valid && !bus.rsp_ready;
      held     = {bus.rsp_err, bus.rsp_y};
      if (bus.cmd_valid && bus.cmd_ready)
        exp_q.push_back(ref_rsp(int'(bus.cmd_a), int'(bus.cmd_b), int'(bus.cmd_op)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    logic acc;
    acc = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = bus.cmd_ready;
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("send_accepted", acc, 1);
  endtask

  task automatic wait_rsp_valid(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (bus.rsp_valid) seen = 1'b1;
      else tick();
    end
    check("wait_rsp_valid", seen, 1);
  endtask

  task automatic wait_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (!busy && !bus.rsp_valid) done = 1'b1;
      else tick();
    end
    check("wait_idle", done, 1);
  endtask

  initial begin
    int         base;
    int         sent;
    logic       acc;
    logic [8:0] exp3 [4];
    logic [8:0] exp5 [5];

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_op    = '0;
    bus.rsp_ready = 1'b0;

    // Reset, then reset again while an op sits in RESP.
    tick();
    tick();
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", bus.cmd_ready, 1);
    check("rel_busy", busy, 0);
    tick();
    send(4'd7, 4'd9, 2'd2);
    wait_rsp_valid(20);
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_s", bus.alu_s, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_y", bus.rsp_y, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_op_count", op_count, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready2", bus.cmd_ready, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel2_cmd_ready", bus.cmd_ready, 1);
    check("rel2_busy", busy, 0);
    tick();

    // Single add with latency checks.
    bus.rsp_ready = 1'b1;
    base          = got_q.size();
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 4'd1;
    bus.cmd_b     = 4'd3;
    bus.cmd_op    = 2'd0;
    tick();
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("lat_e0_valid", bus.rsp_valid, 0);
    tick();
    @(negedge clk);
    check("lat_e1_valid", bus.rsp_valid, 0);
    tick();
    @(negedge clk);
    check("lat_e2_valid", bus.rsp_valid, 1);
    check("add_rsp_y", bus.rsp_y, 8'h04);
    check("add_rsp_err", bus.rsp_err, 0);
    tick();
    @(negedge clk);
    check("add_op_count", op_count, 1);
    check("add_got_n", got_q.size(), base + 1);
    check("add_got", got_q[base], 9'h004);
    check("hold_alu_a", bus.alu_a, 1);
    check("hold_alu_b", bus.alu_b, 3);
    check("hold_alu_s", bus.alu_s, 0);
    tick();

    // Back-to-back sub/mul/div/sub.
    base = got_q.size();
    exp3 = '{9'h002, 9'h008, 9'h002, 9'h0FE};
    send(4'd3, 4'd1, 2'd1);
    send(4'd4, 4'd2, 2'd2);
    send(4'd2, 4'd1, 2'd3);
    send(4'd1, 4'd3, 2'd1);
    wait_idle(60);
    check("b2b_got_n", got_q.size(), base + 4);
    for (int i = 0; i < 4; i++) check($sformatf("b2b_rsp%0d", i), got_q[base+i], exp3[i]);

    // Divide by zero, then a normal op clears the error.
    base = got_q.size();
    send(4'd5, 4'd0, 2'd3);
    send(4'd2, 4'd2, 2'd0);
    wait_idle(60);
    check("div0_got_n", got_q.size(), base + 2);
    check("div0_rsp", got_q[base], 9'h1FF);
    check("after_div0_rsp", got_q[base+1], 9'h004);

    // Backpressure: one op in RESP, four in the FIFO, sixth command refused.
    bus.rsp_ready = 1'b0;
    base = got_q.size();
    exp5 = '{9'h002, 9'h003, 9'h0E1, 9'h0FF, 9'h010};
    send(4'd1, 4'd1, 2'd0);
    send(4'd9, 4'd3, 2'd3);
    send(4'd15, 4'd15, 2'd2);
    send(4'd0, 4'd1, 2'd1);
    send(4'd8, 4'd8, 2'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = 4'd6;
    bus.cmd_b     = 4'd6;
    bus.cmd_op    = 2'd0;
    check("full_cmd_ready", bus.cmd_ready, 0);
    tick();
    tick();
    tick();
    check("full_cmd_ready_held", bus.cmd_ready, 0);
    check("full_busy", busy, 1);
    check("bp_rsp_valid", bus.rsp_valid, 1);
    check("bp_rsp_y", bus.rsp_y, 8'h02);
    check("bp_no_rsp", got_q.size(), base);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_idle(100);
    check("bp_got_n", got_q.size(), base + 5);
    for (int i = 0; i < 5; i++) check($sformatf("bp_rsp%0d", i), got_q[base+i], exp5[i]);

    // 256 random ops from a fresh counter: op_count wraps back to 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("wrap_start", op_count, 0);
    tick();
    base = got_q.size();
    sent = 0;
    for (int cyc = 0; cyc < 20000 && (sent < 256 || busy || bus.rsp_valid || bus.cmd_valid); cyc++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (!bus.cmd_valid && sent < 256 && $urandom_range(0, 1) == 1) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 4'($urandom_range(0, 15));
        bus.cmd_b     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        bus.cmd_op    = 2'($urandom_range(0, 3));
      end
      acc = bus.cmd_valid && bus.cmd_ready;
      tick();
      if (acc) begin
        bus.cmd_valid = 1'b0;
        sent++;
      end
    end
    bus.rsp_ready = 1'b1;
    wait_idle(100);
    check("rand_sent", sent, 256);
    check("rand_got_n", got_q.size(), base + 256);
    check("rand_exp_empty", exp_q.size(), 0);
    @(negedge clk);
    check("wrap_op_count", op_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
